// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and id-width helper for the FIFO write arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_arb_rr_pick.sv
// fifo_arb_rr_pick: combinational rotate-priority picker, first set request at or above start (mod N).
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           any,
  output logic [IDW-1:0] idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(start) + k) % N]) idx = IDW'((int'(start) + k) % N);
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among N requesters.
// Define FIFO_ARB_TAG_EN to prepend grant_id to fifo_din.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 4,
  parameter int MAX_BURST = 2,
  localparam int IDW      = idw(N),
  localparam int BW       = $clog2(MAX_BURST + 1),
`ifdef FIFO_ARB_TAG_EN
  localparam int DW       = W + IDW
`else
  localparam int DW       = W
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  input  logic           fifo_full,
  output logic           fifo_wr_en,
  output logic [DW-1:0]  fifo_din,
  output logic [IDW-1:0] grant_id,
  output logic           busy
);
  state_t         r_state;
  logic [IDW-1:0] r_grant;
  logic [IDW-1:0] r_rr;
  logic [BW-1:0]  r_cnt;
  logic [W-1:0]   w_data [N];
  logic           w_any;
  logic [IDW-1:0] w_pick;
  logic           w_hold;
  logic           w_sel_valid;
  logic           w_beat;
  logic           w_release;
  for (genvar i = 0; i < N; i++) begin : g_slice
    assign w_data[i] = req_data[i*W +: W];
  end
  fifo_arb_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req  (req_valid),
    .start(r_rr),
    .any  (w_any),
    .idx  (w_pick)
  );
  always_comb begin
    w_hold      = r_state == HOLD;
    w_sel_valid = req_valid[r_grant];
    w_beat      = w_hold && w_sel_valid && !fifo_full;
    // release on the beat that completes the burst, or when the owner goes idle with room in the FIFO
    w_release   = (w_beat && r_cnt == BW'(MAX_BURST - 1)) || (w_hold && !w_sel_valid && !fifo_full);
    req_ready   = w_beat ? N'(1) << r_grant : '0;
    fifo_wr_en  = w_beat;
`ifdef FIFO_ARB_TAG_EN
    fifo_din    = w_hold ? {r_grant, w_data[r_grant]} : '0;
`else
    fifo_din    = w_hold ? w_data[r_grant] : '0;
`endif
    grant_id    = r_grant;
    busy        = w_hold;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_rr    <= '0;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_state <= HOLD;
        r_grant <= w_pick;
        r_cnt   <= '0;
      end
    end else begin
      if (w_beat) r_cnt <= r_cnt + 1'b1;
      if (w_release) begin
        r_state <= IDLE;
        r_rr    <= (r_grant == IDW'(N - 1)) ? '0 : r_grant + 1'b1;
      end
    end
  end
endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that shares one register-based FIFO write port between N requesters. Each requester presents data with a valid/ready handshake. The arbiter grants one requester at a time for a bounded burst, drives the FIFO `wr_en`/`din`, and stalls on the FIFO `full` flag. It sits directly in front of `fifo_register_based`, and its outputs connect straight to that FIFO's write side.

## Interface
Parameters:
- `N`, 4: number of requesters (≥2).
- `W`, 4: data width per requester; equals the FIFO `W` when tagging is off.
- `MAX_BURST`, 2: maximum beats accepted per grant (≥1).
- Derived: `IDW = max(1, $clog2(N))`.
- Derived: `BW = $clog2(MAX_BURST+1)`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  N: bit i set means requester i has a beat on its data slice.
- `req_data`  in  N*W: requester i data at `[i*W +: W]`.
- `req_ready`  out  N: one-hot or zero; beat i is transferred when `req_valid[i] && req_ready[i]`.
- `fifo_full`  in  1: FIFO full flag.
- `fifo_wr_en`  out  1: FIFO write enable.
- `fifo_din`  out  W (W+IDW with tagging): FIFO write data.
- `grant_id`  out  IDW: currently granted requester index.
- `busy`  out  1: high while in the HOLD state.

## Operation
- State machine: IDLE and HOLD.
- Registers:
  - `state`
  - `grant_id`
  - `rr_ptr` (IDW bits): the index searched first.
  - `beat_cnt` (BW bits)
- **IDLE**:
  - No writes.
  - If any `req_valid` bit is set, pick the first set bit scanning upward from `rr_ptr`, modulo N.
  - On the next cycle: `grant_id` = the pick, `beat_cnt` = 0, state = HOLD.
  - If no request is valid, stay in IDLE.
- **HOLD**, combinational:
  - `beat = req_valid[grant_id] && !fifo_full`.
  - `fifo_wr_en = beat`.
  - `req_ready[grant_id] = beat`; all other ready bits are 0.
  - `fifo_din = req_data[grant_id]`.
- **HOLD**, sequential:
  - On a beat, `beat_cnt` increments.
  - Release condition (a): the beat just taken makes `beat_cnt` reach MAX_BURST.
  - Release condition (b): `req_valid[grant_id]` is low and `fifo_full` is low.
  - On release: state = IDLE, `rr_ptr = (grant_id+1) mod N`.
- Every grant ends with one IDLE arbitration cycle, so sustained throughput is at most MAX_BURST/(MAX_BURST+1).
- **Full stall**:
  - With `fifo_full` high in HOLD, no beat occurs and `req_ready` is all zero.
  - The grant and `beat_cnt` are held. There is no timeout.
  - A requester that deasserts valid while the FIFO is full keeps the grant until full clears.
- Requesters must hold `req_valid` and data stable until the beat is accepted. The arbiter does not check this.
- **Fairness**: any continuously valid requester is granted within N−1 intervening grants.
- **Simultaneous events**: when the release beat coincides with new requests, arbitration occurs in the following IDLE cycle using the updated `rr_ptr`.

## Timing
- **Reset values**:
  - State: IDLE.
  - `grant_id`, `rr_ptr`, `beat_cnt`: 0.
  - `req_ready`: 0.
  - `fifo_wr_en`: 0.
  - `fifo_din`: 0, because output data is forced to 0 outside HOLD.
  - `busy`: 0.
- **Reset mid-burst**: takes effect on the next edge. Beats already written stay in the FIFO. Any in-progress burst is abandoned with no further writes.
- **Latency**: a request rising in cycle t in IDLE sees its first beat written at edge t+1 at the earliest, with `fifo_wr_en` high during cycle t+1.
- `fifo_wr_en` and `req_ready` are combinational from `req_valid` and `fifo_full`. There are no registered outputs on the data path.

## Configuration
- `FIFO_ARB_TAG_EN`:
  - Defined: `fifo_din` is W+IDW bits, `{grant_id, data}`, so the consumer can identify the source. The FIFO must be instantiated with `W+IDW`.
  - Undefined: `fifo_din` is W bits of data only, and `grant_id` is still output.

## Structure
- Package `fifo_arb_pkg`:
  - State enum (IDLE, HOLD).
  - Function `idw(n)` returning `max(1, $clog2(n))`.
- Sub-module `fifo_arb_rr_pick`:
  - Combinational rotate-priority picker.
  - Inputs: N-bit request vector and IDW-bit start pointer.
  - Outputs: `any` and an IDW-bit index.
- The top level holds the FSM, counters and data mux.

## Test plan
All scenarios use N=4, W=4, MAX_BURST=2, FIFO DEPTH=4.
- **Reset**: assert `rst` for 2 cycles with all `req_valid`=1. Expect all outputs 0, state IDLE, and no `fifo_wr_en` during reset.
- **Single requester**: requester 2 is valid with data 5, then 6, then 7. Expect grant 2. Expect writes 5 and 6 on consecutive cycles, one IDLE cycle, re-grant 2, then write 7.
- **Round-robin**: all four requesters continuously valid with data = index+1. Expect the grant order 0,1,2,3,0. Expect each grant to write exactly 2 beats with a 1-cycle gap between grants.
- **Full stall**: fill the FIFO to 4 entries, then requester 1 becomes valid.
  - Expect `busy`=1, `fifo_wr_en`=0 and `req_ready`=0 while full.
  - After one external read, expect exactly one write in the cycle after full drops.
- **Early release**: requester 3 is valid for one beat, then drops valid.
  - Expect release after 1 beat, then `rr_ptr`=0.
  - With requesters 0 and 3 then both valid, expect the next grant to go to 0.
- **Tagging with `FIFO_ARB_TAG_EN` defined**: requester 2 writes data 0xA. Expect `fifo_din` = 6'b10_1010.
